tile_noc_packetizer: RTL
========================

Name: tile_noc_packetizer

Overview:
- Tile-side injection endpoint for the 2D mesh. Converts a packet request and a payload-word stream into head/body/tail flits on one valid/ready flit port, which connects to the tile's Local router port.
- One instance per tile, between the tile's DMA/compute master and the mesh.
- Completes the path whose loopback stub currently sits in the mesh.

Parameters:
- ROWS, 4, mesh rows; a destination row must be < ROWS
- COLS, 4, mesh columns; a destination column must be < COLS
- FLIT_W, 64, flit width; payload width is FLIT_W-2
- SRC_ROW, 0, this tile's row, placed in head flit
- SRC_COL, 0, this tile's column, placed in head flit

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  packet request valid
- req_ready  out  1  packet request accepted when req_valid & req_ready
- req_dst_row  in  4  destination row
- req_dst_col  in  4  destination column
- req_len  in  8  payload flit count, 0..255
- pld_data  in  FLIT_W-2  payload word
- pld_valid  in  1  payload valid
- pld_ready  out  1  payload accepted when pld_valid & pld_ready
- flit_out  out  FLIT_W  flit to router Local port
- valid_out  out  1  flit valid
- ready_in  in  1  router Local port ready
- busy  out  1  packet in progress (state != IDLE or valid_out)
- err_drop  out  1  one-cycle pulse: request dropped, destination out of range

Behaviour:
- Flit type field [FLIT_W-1:FLIT_W-2]: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head with len 0).
- Head flit fields:
  - [61:58] dst_row, [57:54] dst_col
  - [53:50] SRC_ROW, [49:46] SRC_COL
  - [45:38] len
  - [37:0] zero, except in the optional-feature field
- Body and tail flits: [FLIT_W-3:0] = pld_data, passed unmodified.
- Output is a single registered slot. Define slot_free = !valid_out | ready_in.
- valid_out stays high and flit_out stays stable until ready_in. The slot reloads in the same cycle it drains, so throughput is 1 flit/clk.
- FSM states: IDLE, BODY, DROP.
  - IDLE: req_ready = slot_free.
    - Accept with in-range destination: load a head flit (type 2'b11 if req_len==0), visible on the next cycle. Next state is IDLE if len==0, else BODY with rem=req_len.
    - Accept with req_dst_row>=ROWS or req_dst_col>=COLS: no flit is emitted and err_drop pulses the next cycle. Next state is IDLE if len==0, else DROP with rem=req_len.
  - BODY: pld_ready = slot_free; req_ready=0.
    - Each accepted word loads a flit typed tail if rem==1, else body, and rem decrements.
    - When rem reaches 0, next state is IDLE.
  - DROP: pld_ready=1. Accepted words are discarded and rem decrements. When rem reaches 0, next state is IDLE.
- pld_ready=0 in IDLE; payload presented early waits.
- Back-to-back packets: in the cycle the tail loads, the FSM returns to IDLE. The next request is accepted on the following cycle if slot_free, giving one bubble at most.
- Destination equal to (SRC_ROW,SRC_COL) is legal and emitted normally.
- Reset values: valid_out=0, flit_out=0, req_ready=0, pld_ready=0, busy=0, err_drop=0, state=IDLE, rem=0.
- Asserting rst_n low mid-packet abandons the packet immediately. Recovery of partial packets in the mesh is out of scope.
- Arithmetic: rem is 8 bits and never decrements below 0.

Optional Feature:
- Macro NI_SEQ_EN.
- When defined: an 8-bit sequence counter, reset 0, is placed in head flit [37:30]. It increments once per emitted head flit and wraps 255->0. Dropped requests do not increment it.
- When undefined: [37:30] is zero and no counter exists.

Test Plan:
- Request dst=(2,3), len=3, payload A,B,C, ready_in=1 -> flits head(dst 2,3 src 0,0 len 3), body A, body B, tail C on 4 consecutive cycles; head appears 1 cycle after the request handshake.
- len=0 request -> a single flit with type 2'b11 and len field 0; busy low the cycle after it drains; pld_ready never asserted.
- ready_in held low 5 cycles during body B -> flit_out/valid_out stable all 5 cycles, pld_ready=0, no payload lost; tail follows after release.
- dst=(4,0) with ROWS=4, len=2 -> no valid_out, err_drop high exactly 1 cycle, 2 payload words consumed, next valid request emitted normally.
- rst_n pulsed low after head+1 body of a len=4 packet -> valid_out=0 and state IDLE immediately; the next request starts a fresh head.
- With NI_SEQ_EN, send 257 len=0 packets -> seq fields 0..255, then 0.

Source files
------------

// File: rtl/tile_noc_packetizer_if.sv
// Flit-injection bundle between a tile master, the packetizer and the router Local port.
// The master modport is the tile/router side; the slave modport is the packetizer.
`timescale 1ns/1ps
interface tile_noc_packetizer_if #(
    parameter int FLIT_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_dst_row;
    logic [3:0]        req_dst_col;
    logic [7:0]        req_len;
    logic [FLIT_W-3:0] pld_data;
    logic              pld_valid;
    logic              pld_ready;
    logic [FLIT_W-1:0] flit_out;
    logic              valid_out;
    logic              ready_in;
    logic              busy;
    logic              err_drop;

    modport master (
        output req_valid, req_dst_row, req_dst_col, req_len,
        output pld_data, pld_valid, ready_in,
        input  req_ready, pld_ready, flit_out, valid_out, busy, err_drop
    );

    modport slave (
        input  req_valid, req_dst_row, req_dst_col, req_len,
        input  pld_data, pld_valid, ready_in,
        output req_ready, pld_ready, flit_out, valid_out, busy, err_drop
    );
endinterface

// File: rtl/tile_noc_packetizer.sv
// Tile injection endpoint: turns a packet request plus payload stream into head/body/tail flits.
// Optional macro NI_SEQ_EN adds an 8-bit per-head sequence number in head flit [37:30].
`timescale 1ns/1ps
module tile_noc_packetizer #(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int FLIT_W  = 64,
    parameter int SRC_ROW = 0,
    parameter int SRC_COL = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    tile_noc_packetizer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BODY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        rem;
    logic [7:0]        rem_nxt;
    logic              valid_q;
    logic              valid_nxt;
    logic [FLIT_W-1:0] flit_q;
    logic [FLIT_W-1:0] flit_nxt;
    logic              err_q;
    logic              err_nxt;
    logic              run_q;
    logic [7:0]        head_seq;

    logic slot_free;
    logic dst_ok;
    logic req_fire;
    logic pld_fire;

`ifdef NI_SEQ_EN
    logic [7:0] seq;
    logic [7:0] seq_nxt;
    assign head_seq = seq;
`else
    assign head_seq = 8'd0;
`endif

    function automatic logic [7:0] rem_dec(input logic [7:0] r);
        return (r == 8'd0) ? 8'd0 : r - 8'd1;
    endfunction

    function automatic logic [FLIT_W-1:0] head_flit(
        input logic [3:0] row,
        input logic [3:0] col,
        input logic [7:0] len,
        input logic [7:0] sq
    );
        logic [FLIT_W-1:0] f;
        f                  = '0;
        f[FLIT_W-1 -: 2]   = (len == 8'd0) ? 2'b11 : 2'b10;
        f[FLIT_W-3 -: 4]   = row;
        f[FLIT_W-7 -: 4]   = col;
        f[FLIT_W-11 -: 4]  = 4'(SRC_ROW);
        f[FLIT_W-15 -: 4]  = 4'(SRC_COL);
        f[FLIT_W-19 -: 8]  = len;
        f[FLIT_W-27 -: 8]  = sq;
        return f;
    endfunction

    // The slot can take a new flit when empty or when its current flit leaves this cycle.
    assign slot_free = !valid_q || bus.ready_in;
    assign dst_ok    = (int'(bus.req_dst_row) < ROWS) && (int'(bus.req_dst_col) < COLS);

    // run_q keeps the handshakes closed while rst_n is low and for the first edge after release.
    assign bus.req_ready = run_q && (state == IDLE) && slot_free;
    assign bus.pld_ready = run_q && (((state == BODY) && slot_free) || (state == DROP));
    assign req_fire      = bus.req_valid && bus.req_ready;
    assign pld_fire      = bus.pld_valid && bus.pld_ready;

    assign bus.flit_out  = flit_q;
    assign bus.valid_out = valid_q;
    assign bus.err_drop  = err_q;
    assign bus.busy      = (state != IDLE) || valid_q;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        err_nxt   = 1'b0;
        flit_nxt  = flit_q;
        valid_nxt = valid_q && !bus.ready_in;
`ifdef NI_SEQ_EN
        seq_nxt   = seq;
`endif
        unique case (state)
            IDLE: begin
                if (req_fire) begin
                    rem_nxt = bus.req_len;
                    if (dst_ok) begin
                        flit_nxt  = head_flit(bus.req_dst_row, bus.req_dst_col, bus.req_len, head_seq);
                        valid_nxt = 1'b1;
`ifdef NI_SEQ_EN
                        seq_nxt   = seq + 8'd1;
`endif
                        state_nxt = (bus.req_len == 8'd0) ? IDLE : BODY;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = (bus.req_len == 8'd0) ? IDLE : DROP;
                    end
                end
            end
            BODY: begin
                if (pld_fire) begin
                    flit_nxt  = {(rem == 8'd1) ? 2'b01 : 2'b00, bus.pld_data};
                    valid_nxt = 1'b1;
                    rem_nxt   = rem_dec(rem);
                    if (rem <= 8'd1) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (pld_fire) begin
                    rem_nxt = rem_dec(rem);
                    if (rem <= 8'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rem     <= 8'd0;
            valid_q <= 1'b0;
            flit_q  <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
`ifdef NI_SEQ_EN
            seq     <= 8'd0;
`endif
        end else begin
            state   <= state_nxt;
            rem     <= rem_nxt;
            valid_q <= valid_nxt;
            flit_q  <= flit_nxt;
            err_q   <= err_nxt;
            run_q   <= 1'b1;
`ifdef NI_SEQ_EN
            seq     <= seq_nxt;
`endif
        end
    end

endmodule
